// File: rtl/clk_seq_pkg.sv
// Shared encodings for the clock-domain power/lock sequencer: FSM states,
// per-domain status and domain index constants.
package clk_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PWRUP     = 2'd1,
      ST_WAIT_LOCK = 2'd2,
      ST_SETTLE    = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      DOM_OFF     = 2'd0,
      DOM_PENDING = 2'd1,
      DOM_ON      = 2'd2,
      DOM_FAULT   = 2'd3
   } dom_status_e;

   localparam int IDX_W          = 3;
   localparam int HDD_DOMAIN_IDX = 0;

endpackage

// File: rtl/clk_domain_sequencer_if.sv
// Bundle of per-domain request/status signals between the register block
// (master) and the clock-domain sequencer (slave).
interface clk_domain_sequencer_if #(parameter int N = 4);
   import clk_seq_pkg::*;

   // No valid/ready: domain_enable is a quasi-static level, fault_clear is a
   // one-cycle pulse, pll_locked_raw is asynchronous; all outputs are levels.
   logic [N-1:0] domain_enable;
   logic [N-1:0] pll_locked_raw;
   logic [N-1:0] fault_clear;
   logic [N-1:0] pll_pwrdwn;
   logic [N-1:0] pll_rst;
   logic [N-1:0] locked;
   logic [N-1:0] clk_en;
   logic [N-1:0] fault;
   logic         busy;
   logic [2:0]   active_idx;
   seq_state_e   state_dbg;

   modport master (
      output domain_enable, pll_locked_raw, fault_clear,
      input  pll_pwrdwn, pll_rst, locked, clk_en, fault, busy, active_idx, state_dbg
   );

   modport slave (
      input  domain_enable, pll_locked_raw, fault_clear,
      output pll_pwrdwn, pll_rst, locked, clk_en, fault, busy, active_idx, state_dbg
   );

endinterface

// File: rtl/clk_seq_lock_sync.sv
// Per-bit two-flop synchroniser bringing asynchronous PLL lock indications
// into the reference clock domain.
module clk_seq_lock_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/clk_domain_sequencer.sv
// Power/lock sequencer for gated clock domains: powers one PLL up at a time,
// qualifies its lock over a settle window, then opens the domain clock gate.
module clk_domain_sequencer
   import clk_seq_pkg::*;
#(
   parameter int NUM_DOMAINS    = 4,
   parameter int RST_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int SETTLE_CYCLES  = 64,
   parameter int CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   clk_domain_sequencer_if.slave bus
);

   logic [NUM_DOMAINS-1:0] lock_sync;
   seq_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       active_q, active_d, pick_idx;
   logic                   busy_q, busy_d;
   logic [NUM_DOMAINS-1:0] pwrdwn_q, pwrdwn_d, rst_q, rst_d;
   logic [NUM_DOMAINS-1:0] locked_q, locked_d, clk_en_q, clk_en_d, fault_q, fault_d;
   dom_status_e            status_q [NUM_DOMAINS];
   dom_status_e            status_d [NUM_DOMAINS];
   logic                   pick_valid, act_en, act_lock;
   logic                   do_start, do_rst_rel, do_timeout, do_commit;

   clk_seq_lock_sync #(.WIDTH(NUM_DOMAINS)) u_lock_sync (
      .clk  (clk),
      .reset(reset),
      .d    (bus.pll_locked_raw),
      .q    (lock_sync)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         active_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      act_en     = 1'b0;
      act_lock   = 1'b0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         if (IDX_W'(i) == active_q) begin
            act_en   = bus.domain_enable[i];
            act_lock = lock_sync[i];
         end
      end
      // Descending scan so the lowest pending index wins.
      for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
         if (status_q[i] == DOM_PENDING && bus.domain_enable[i]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(i);
         end
      end
      do_start   = (state_q == ST_IDLE) && pick_valid;
      do_rst_rel = (state_q == ST_PWRUP) && act_en && (cnt_q == CNT_W'(RST_CYCLES - 1));
      do_timeout = (state_q == ST_WAIT_LOCK) && act_en && !act_lock &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      do_commit  = (state_q == ST_SETTLE) && act_en && act_lock &&
                   (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (do_start) state_d = ST_PWRUP;
         ST_PWRUP:     if (!act_en) state_d = ST_IDLE;
                       else if (do_rst_rel) state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK: if (!act_en || do_timeout) state_d = ST_IDLE;
                       else if (act_lock) state_d = ST_SETTLE;
         ST_SETTLE:    if (!act_en || do_commit) state_d = ST_IDLE;
                       else if (!act_lock) state_d = ST_WAIT_LOCK;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = (state_q == ST_IDLE || state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      busy_d   = (state_d != ST_IDLE);
      active_d = do_start ? pick_idx : ((state_d == ST_IDLE) ? '0 : active_q);
      pwrdwn_d = pwrdwn_q;
      rst_d    = rst_q;
      locked_d = locked_q;
      clk_en_d = clk_en_q;
      fault_d  = fault_q;
      status_d = status_q;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         if (do_start && pick_idx == IDX_W'(i)) begin
            pwrdwn_d[i] = 1'b0;
            rst_d[i]    = 1'b1;
         end
         if (active_q == IDX_W'(i)) begin
            if (do_rst_rel) rst_d[i] = 1'b0;
            if (do_timeout) begin
               fault_d[i]  = 1'b1;
               pwrdwn_d[i] = 1'b1;
               rst_d[i]    = 1'b1;
               status_d[i] = DOM_FAULT;
            end
            if (do_commit) begin
               locked_d[i] = 1'b1;
               clk_en_d[i] = 1'b1;
               status_d[i] = DOM_ON;
            end
         end
         // Disable gates the clock first; the PLL is stopped one edge later.
         if (!bus.domain_enable[i]) begin
            fault_d[i] = 1'b0;
            if (status_q[i] != DOM_OFF) begin
               status_d[i] = DOM_OFF;
               clk_en_d[i] = 1'b0;
               locked_d[i] = 1'b0;
            end else begin
               pwrdwn_d[i] = 1'b1;
               rst_d[i]    = 1'b1;
            end
         end else begin
            case (status_q[i])
               DOM_OFF:   if (!fault_q[i]) status_d[i] = DOM_PENDING;
               DOM_ON:    if (!lock_sync[i]) begin
                             locked_d[i] = 1'b0;
                             clk_en_d[i] = 1'b0;
                             status_d[i] = DOM_PENDING;
                          end
               DOM_FAULT: if (bus.fault_clear[i]) begin
                             fault_d[i]  = 1'b0;
                             status_d[i] = DOM_PENDING;
                          end
               default:   ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pwrdwn_q <= '1;
         rst_q    <= '1;
         locked_q <= '0;
         clk_en_q <= '0;
         fault_q  <= '0;
         for (int i = 0; i < NUM_DOMAINS; i++) status_q[i] <= DOM_OFF;
      end else begin
         pwrdwn_q <= pwrdwn_d;
         rst_q    <= rst_d;
         locked_q <= locked_d;
         clk_en_q <= clk_en_d;
         fault_q  <= fault_d;
         for (int i = 0; i < NUM_DOMAINS; i++) status_q[i] <= status_d[i];
      end
   end

   assign bus.pll_pwrdwn = pwrdwn_q;
   assign bus.pll_rst    = rst_q;
   assign bus.locked     = locked_q;
   assign bus.clk_en     = clk_en_q;
   assign bus.fault      = fault_q;
   assign bus.busy       = busy_q;
   assign bus.active_idx = active_q;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_clk_domain_sequencer.sv
// Self-checking bench for clk_domain_sequencer: behavioural PLL model plus a
// lock-event scoreboard keyed by domain index and raw-lock-to-locked latency.
module tb_clk_domain_sequencer;
   import clk_seq_pkg::*;

   localparam int N        = 4;
   localparam int RST_C    = 16;
   localparam int TMO_C    = 4096;
   localparam int SET_C    = 64;
   localparam int LOCK_LAT = 2 + SET_C + 1;
   localparam int PLL_DLY  = 100;
   localparam logic [31:0] ALL = 32'((1 << N) - 1);

   // clock / reset
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   clk_domain_sequencer_if #(.N(N)) bus ();

   clk_domain_sequencer #(
      .NUM_DOMAINS   (N),
      .RST_CYCLES    (RST_C),
      .TIMEOUT_CYCLES(TMO_C),
      .SETTLE_CYCLES (SET_C),
      .CNT_W         (16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // PLL model: lock rises PLL_DLY cycles after reset release unless suppressed
   logic [N-1:0] never_lock = '0;
   logic [N-1:0] drop_ovr   = '0;
   int lk_cnt   [N];
   int rise_cyc [N];
   int fall_cyc [N];

   initial begin
      logic nxt;
      bus.pll_locked_raw = '0;
      for (int i = 0; i < N; i++) begin
         lk_cnt[i]   = 0;
         rise_cyc[i] = 0;
         fall_cyc[i] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (bus.pll_pwrdwn[i] || bus.pll_rst[i]) lk_cnt[i] = 0;
            else if (lk_cnt[i] < PLL_DLY) lk_cnt[i]++;
            nxt = (lk_cnt[i] >= PLL_DLY) && !never_lock[i] && !drop_ovr[i];
            if (nxt && !bus.pll_locked_raw[i]) rise_cyc[i] = cyc;
            if (!nxt && bus.pll_locked_raw[i]) fall_cyc[i] = cyc;
            bus.pll_locked_raw[i] = nxt;
         end
      end
   end

   // scoreboard: {domain index, raw-lock-to-locked latency}
   logic [15:0]  exp_q[$];
   logic [N-1:0] prev_locked = '0;

   initial begin
      logic [15:0] got, exp;
      forever begin
         @(negedge clk);
         chk("inv_clken", 32'(bus.clk_en & (~bus.locked | bus.pll_pwrdwn)), 32'd0);
         for (int i = 0; i < N; i++) begin
            if (bus.locked[i] && !prev_locked[i]) begin
               got = {3'(i), 13'(cyc - rise_cyc[i])};
               if (exp_q.size() == 0) begin
                  chk("lock_unexpected", 32'(got), 32'hFFFF);
               end else begin
                  exp = exp_q.pop_front();
                  chk("lock_event", 32'(got), 32'(exp));
               end
               chk("clk_en_with_lock", 32'(bus.clk_en[i]), 32'd1);
            end
         end
         prev_locked = bus.locked;
      end
   end

   // driver tasks
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pwrdwn"}, 32'(bus.pll_pwrdwn), ALL);
      chk({tag, "_pllrst"}, 32'(bus.pll_rst), ALL);
      chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
      chk({tag, "_clken"},  32'(bus.clk_en), 32'd0);
      chk({tag, "_fault"},  32'(bus.fault), 32'd0);
      chk({tag, "_busy"},   32'(bus.busy), 32'd0);
      chk({tag, "_idx"},    32'(bus.active_idx), 32'd0);
      chk({tag, "_state"},  32'(bus.state_dbg), 32'(ST_IDLE));
   endtask

   task automatic wait_locked(input int idx, input int budget);
      int n = 0;
      while (!bus.locked[idx] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_locked", 32'(bus.locked[idx]), 32'd1);
   endtask

   task automatic expect_lock(input int idx);
      exp_q.push_back({3'(idx), 13'(LOCK_LAT)});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, t0, t1;
      bus.domain_enable = '0;
      bus.fault_clear   = '0;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;

      // idle with everything disabled
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         chk("idle_pwrdwn", 32'(bus.pll_pwrdwn), ALL);
         chk("idle_clken", 32'(bus.clk_en), 32'd0);
         chk("idle_busy", 32'(bus.busy), 32'd0);
      end

      // single domain bring-up
      expect_lock(0);
      bus.domain_enable[0] = 1'b1;
      wait_locked(0, 400);
      chk("d0_clken", 32'(bus.clk_en[0]), 32'd1);
      @(negedge clk);
      chk("d0_busy_after", 32'(bus.busy), 32'd0);

      // two simultaneous requests, lowest index first
      expect_lock(1);
      expect_lock(2);
      bus.domain_enable[2:1] = 2'b11;
      @(negedge clk);
      @(negedge clk);
      chk("arb_idx", 32'(bus.active_idx), 32'd1);
      chk("arb_busy", 32'(bus.busy), 32'd1);
      n = 0;
      while (!bus.locked[1] && n < 400) begin
         chk("d2_held_off", 32'(bus.pll_pwrdwn[2]), 32'd1);
         @(negedge clk);
         n++;
      end
      chk("wait_locked1", 32'(bus.locked[1]), 32'd1);
      wait_locked(2, 400);

      // disable an ON domain: gate first, power down one edge later
      bus.domain_enable[0] = 1'b0;
      @(negedge clk);
      chk("dis_clken", 32'(bus.clk_en[0]), 32'd0);
      chk("dis_locked", 32'(bus.locked[0]), 32'd0);
      chk("dis_pwrdwn_early", 32'(bus.pll_pwrdwn[0]), 32'd0);
      @(negedge clk);
      chk("dis_pwrdwn", 32'(bus.pll_pwrdwn[0]), 32'd1);
      chk("dis_pllrst", 32'(bus.pll_rst[0]), 32'd1);

      // lock timeout
      never_lock[0] = 1'b1;
      bus.domain_enable[0] = 1'b1;
      n = 0;
      while (bus.pll_pwrdwn[0] && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_pwrup", 32'(bus.pll_pwrdwn[0]), 32'd0);
      t0 = cyc;
      n = 0;
      while (!bus.fault[0] && n < RST_C + TMO_C + 100) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      chk("tmo_cycles", 32'(t1 - t0), 32'(RST_C + TMO_C));
      chk("tmo_fault", 32'(bus.fault[0]), 32'd1);
      chk("tmo_pwrdwn", 32'(bus.pll_pwrdwn[0]), 32'd1);
      chk("tmo_pllrst", 32'(bus.pll_rst[0]), 32'd1);
      chk("tmo_busy", 32'(bus.busy), 32'd0);
      repeat (20) @(negedge clk);
      chk("fault_sticky", 32'(bus.fault[0]), 32'd1);
      chk("fault_blocks", 32'(bus.pll_pwrdwn[0]), 32'd1);

      // fault_clear re-sequences with the PLL now healthy
      never_lock[0] = 1'b0;
      expect_lock(0);
      bus.fault_clear[0] = 1'b1;
      @(negedge clk);
      bus.fault_clear[0] = 1'b0;
      chk("fclr_fault", 32'(bus.fault[0]), 32'd0);
      wait_locked(0, 400);

      // lock loss while ON
      drop_ovr[0] = 1'b1;
      n = 0;
      while (bus.clk_en[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drop_lat", 32'(cyc - fall_cyc[0]), 32'd3);
      repeat (7) @(negedge clk);
      drop_ovr[0] = 1'b0;
      expect_lock(0);
      wait_locked(0, 400);

      // disable during SETTLE
      bus.domain_enable[0] = 1'b0;
      repeat (3) @(negedge clk);
      bus.domain_enable[0] = 1'b1;
      n = 0;
      while (!(bus.state_dbg == ST_SETTLE && bus.active_idx == 3'd0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("reach_settle", 32'(bus.state_dbg), 32'(ST_SETTLE));
      bus.domain_enable[0] = 1'b0;
      @(negedge clk);
      chk("abort_state", 32'(bus.state_dbg), 32'(ST_IDLE));
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_pwrdwn_early", 32'(bus.pll_pwrdwn[0]), 32'd0);
      @(negedge clk);
      chk("abort_pwrdwn", 32'(bus.pll_pwrdwn[0]), 32'd1);
      for (int k = 0; k < 80; k++) begin
         chk("abort_no_clken", 32'(bus.clk_en[0]), 32'd0);
         @(negedge clk);
      end

      // reset asserted mid-sequence
      bus.domain_enable[3] = 1'b1;
      repeat (4) @(negedge clk);
      chk("seq3_busy", 32'(bus.busy), 32'd1);
      chk("seq3_idx", 32'(bus.active_idx), 32'd3);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      bus.domain_enable = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_domain_sequencer.md
Name: clk_domain_sequencer

Overview:
- Parametrised power/lock sequencer for NUM_DOMAINS gated clock domains, for example the 300 MHz HDD domain and future ones.
- Replaces per-wizard ad-hoc enable/lock logic. Brings up one PLL at a time to limit inrush, then qualifies lock over a settle window before asserting clk_en.
- Handles lock loss, disable and lock timeout per domain.
- Sits beside the clock wizards on the always-on 200 MHz reference clock.

Parameters:
- NUM_DOMAINS, 4: number of managed clock domains (1..8).
- RST_CYCLES, 16: PLL reset hold after power-up request.
- TIMEOUT_CYCLES, 4096: maximum cycles waiting for raw lock before fault.
- SETTLE_CYCLES, 64: consecutive synced-lock cycles required before commit.
- CNT_W, 16: width of the shared sequencing counter; must hold max(RST_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES).

Ports:
- clk  in  1  200 MHz always-on reference clock; sole clock.
- reset  in  1  synchronous, active-high.
- domain_enable  in  NUM_DOMAINS  per-domain request (level; quasi-static, from config registers).
- pll_locked_raw  in  NUM_DOMAINS  asynchronous PLL lock; 2-FF synchronised internally.
- fault_clear  in  NUM_DOMAINS  one-cycle pulse; clears fault[i].
- pll_pwrdwn  out  NUM_DOMAINS  1 = PLL powered down.
- pll_rst  out  NUM_DOMAINS  1 = PLL held in reset.
- locked  out  NUM_DOMAINS  qualified lock.
- clk_en  out  NUM_DOMAINS  BUFGCE enable for the domain clock.
- fault  out  NUM_DOMAINS  sticky lock-timeout flag.
- busy  out  1  sequencer is bringing a domain up.
- active_idx  out  3  index being sequenced; 0 when idle.

Behaviour:
- Reset values: pll_pwrdwn all 1, pll_rst all 1, locked/clk_en/fault all 0, busy 0, active_idx 0, FSM IDLE, sync flops 0.
- Per-domain status is one of OFF, PENDING, ON, FAULT.
  - OFF to PENDING when domain_enable[i]=1 and fault[i]=0.
  - Sequencer commit moves PENDING to ON.
  - Timeout moves the domain to FAULT.
- Sequencer FSM: IDLE, PWRUP, WAIT_LOCK, SETTLE.
  - IDLE: select the lowest-index PENDING domain. Next cycle: PWRUP, busy=1, active_idx=i, pll_pwrdwn[i]=0, pll_rst[i]=1, counter=0.
  - PWRUP: after RST_CYCLES cycles, deassert pll_rst[i] and go to WAIT_LOCK, counter=0.
  - WAIT_LOCK: if synced lock=1, go to SETTLE, counter=0.
    - When counter reaches TIMEOUT_CYCLES-1 without lock: fault[i]=1, pll_pwrdwn[i]=1, pll_rst[i]=1, go to IDLE.
  - SETTLE: synced lock=0 returns to WAIT_LOCK; the timeout counter restarts from 0.
    - After SETTLE_CYCLES consecutive lock-high cycles: locked[i]=1 and clk_en[i]=1 on the same clock edge, status ON, go to IDLE, busy=0.
- Bring-up latency: raw lock to locked is 2 sync cycles plus SETTLE_CYCLES plus 1.
- Lock loss in ON: synced lock=0 clears locked[i] and clk_en[i] on the next edge. Status returns to PENDING, PLL stays powered, pll_rst[i] is pulsed via re-sequencing.
- Disable:
  - domain_enable[i]=0 clears clk_en[i] and locked[i] on the next edge. pll_pwrdwn[i]=1 and pll_rst[i]=1 one edge later, so the clock is gated before the PLL stops. Status goes to OFF.
  - If i is the active domain, the FSM aborts to IDLE in that same cycle.
- Fault:
  - fault[i] blocks re-request.
  - Cleared by fault_clear[i], or by domain_enable[i]=0. Clearing is not allowed while domain_enable[i]=1 and fault_clear[i]=0.
  - After a clear with enable still high, the domain re-enters PENDING the next cycle.
- Simultaneous events:
  - Disable wins over commit in the same cycle.
  - Multiple PENDING domains are served strictly by lowest index. A lock-lost re-queue does not pre-empt the active sequence.
- Invariants: clk_en[i] is never 1 while locked[i]=0; clk_en[i] is never 1 while pll_pwrdwn[i]=1.
- Reset asserted mid-sequence returns every output to its reset value on the next edge.

Decomposition:
- Shared package clk_seq_pkg holds:
  - the FSM state encoding (IDLE, PWRUP, WAIT_LOCK, SETTLE);
  - the domain status encoding (OFF, PENDING, ON, FAULT);
  - the domain index constants, including HDD_DOMAIN_IDX=0.
- One sub-module, clk_seq_lock_sync: per-bit 2-FF synchroniser, instantiated NUM_DOMAINS wide.
- Arbiter and FSM stay in the top level.

Test Plan:
- Reset release with all enables 0: pll_pwrdwn=4'b1111, clk_en=0, busy=0 held for 100 cycles.
- Enable domain 0; the bench PLL model raises lock 100 cycles after pll_rst falls. Required: locked[0] exactly 2+64+1 cycles after raw lock, clk_en[0]=1 in the same cycle, busy=0 the next cycle.
- Enable domains 2 and 1 together: domain 1 is sequenced first (active_idx=1), and domain 2's pll_pwrdwn stays 1 until domain 1 commits.
- Raw lock never rises: fault[0]=1 after RST_CYCLES+4096 cycles, and pll_pwrdwn[0] returns to 1. fault_clear[0] then re-sequences the domain and it locks.
- With domain 0 ON, drop raw lock for 10 cycles: clk_en[0] falls 3 cycles after the drop, and the domain re-locks after raw lock returns.
- Deassert domain_enable[0] during SETTLE: FSM returns to IDLE, clk_en[0] never pulses, pll_pwrdwn[0]=1 two cycles after the drop.
